dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's
//  memory stage (dmem_addr/dmem_dataout/dmem_rw/dmem_datain) and the external data memory.
//  Drives cpu_stall, which becomes the core's global STALL. Refills whole lines via a
//  request/accept + beat-valid burst handshake. Word accesses only.
// PARAMETERS
//  INDEX_BITS   6   line index width; 2**INDEX_BITS lines
//  OFFSET_BITS  2   word-offset width; LINE_WORDS = 2**OFFSET_BITS words per line
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset_n    in   1   asynchronous, active-low reset
//  cpu_addr   in   32  byte address from memory stage; bits [1:0] ignored
//  cpu_wdata  in   32  store data
//  cpu_rd     in   1   load request this cycle
//  cpu_wr     in   1   store request this cycle (wins if cpu_rd also set)
//  cpu_rdata  out  32  load data, valid when cpu_rd & ~cpu_stall
//  cpu_stall  out  1   freeze pipeline; combinational
//  mem_req    out  1   memory request, held until mem_ready
//  mem_we     out  1   1 = single-word write, 0 = line read burst
//  mem_addr   out  32  word address (write) or line-aligned address (burst)
//  mem_wdata  out  32  write data
//  mem_ready  in   1   request accepted this cycle
//  mem_rdata  in   32  burst beat data
//  mem_valid  in   1   burst beat valid; beats arrive offset 0..LINE_WORDS-1, in order
// BEHAVIOUR
//  - Tag = addr[31:INDEX_BITS+OFFSET_BITS+2]; index/offset below it. Valid bit per line.
//  - Reset: all valid bits 0, state IDLE, beat count 0, wr_done 0; mem_req, mem_we,
//    cpu_stall, cpu_rdata = 0; mem_addr, mem_wdata = 0. Async reset mid-burst aborts:
//    mem_req drops immediately; the partially filled line stays invalid.
//  - FSM states: IDLE, RD_REQ, RD_BEAT, WR_REQ.
//    IDLE: read hit -> cpu_rdata = data array word combinationally, stall 0, 0 wait cycles.
//      read miss -> stall 1 same cycle, goto RD_REQ.
//      store with wr_done 0 -> stall 1, goto WR_REQ. Store with wr_done 1 -> stall 0,
//      clear wr_done (completed store is not reissued).
//    RD_REQ: mem_req=1, mem_we=0, mem_addr = {addr[31:OFFSET_BITS+2], 0}. On mem_ready
//      goto RD_BEAT, beat count = 0.
//    RD_BEAT: each mem_valid writes mem_rdata to word[beat], beat+1. On last beat, write
//      tag, set valid, goto IDLE. The next cycle re-looks-up and hits, so stall drops.
//      Read-miss latency = accept wait + LINE_WORDS beats + 1 cycle.
//    WR_REQ: mem_req=1, mem_we=1, mem_addr = {addr[31:2], 2'b00}, mem_wdata = cpu_wdata.
//      On mem_ready: if line valid and tag matches, update that word in cache (same edge),
//      set wr_done, goto IDLE. Miss: no allocation, cache unchanged.
//  - cpu_stall = (state != IDLE) | (IDLE & cpu_rd & ~cpu_wr & miss) | (IDLE & cpu_wr & ~wr_done).
//  - mem_req stays 1 every cycle in RD_REQ/WR_REQ until mem_ready. Request fields must
//    not change while mem_req=1; cpu inputs are stable because the pipeline is stalled.
//  - mem_valid outside RD_BEAT and mem_ready outside *_REQ are ignored. Beats beyond
//    LINE_WORDS are not expected; the beat counter wraps modulo LINE_WORDS.
//  - No read or write activity when cpu_rd = cpu_wr = 0. Stall 0, FSM holds IDLE.
// TESTING
//  1 Cold read 0x100, 2-cycle accept, 4 beats -> mem_addr=0x100, stall high 7 cycles,
//    then rdata=beat at offset 0.
//  2 Read 0x104 after test 1 -> hit, stall 0, rdata = beat 1, no mem_req.
//  3 Store 0xDEADBEEF to 0x108 (hit) -> one mem_we write to 0x108. Later read 0x108
//    returns 0xDEADBEEF with no refill.
//  4 Store to uncached 0x2000 -> one write and stall drops the cycle after mem_ready.
//    Read 0x2000 then misses and refills.
//  5 Alias: read 0x100, then read 0x100+(1<<(INDEX_BITS+4)) -> second refills, and
//    re-reading 0x100 misses again.
//  6 Assert reset_n low during beat 2 of a refill -> mem_req=0 and stall=0 at once.
//    Re-read of that line misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Refills whole lines by burst and forwards every store to memory as a single-word write.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int unsigned LINES      = 1 << INDEX_BITS;
  localparam int unsigned LINE_WORDS = 1 << OFFSET_BITS;
  localparam int unsigned TAG_LSB    = INDEX_BITS + OFFSET_BITS + 2;
  localparam int unsigned TAG_BITS   = 32 - TAG_LSB;
  localparam int unsigned WIDX_BITS  = INDEX_BITS + OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_BEAT, WR_REQ} state_t;

  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;
  logic                   wr_done_q, wr_done_d;
  logic                   mem_req_d, mem_we_d;
  logic [31:0]            mem_addr_d, mem_wdata_d;

  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [31:0]            data_q [LINES*LINE_WORDS];

  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_idx;
  logic [OFFSET_BITS-1:0] addr_off;
  logic                   hit;
  logic                   stall_raw;
  logic                   fill_we, fill_commit, fill_inval, store_we;
  logic                   unused_addr_bits;

  assign addr_tag         = cpu_addr[31:TAG_LSB];
  assign addr_idx         = cpu_addr[TAG_LSB-1:OFFSET_BITS+2];
  assign addr_off         = cpu_addr[OFFSET_BITS+1:2];
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign hit              = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Reset gates the combinational outputs so the core sees a quiet cache while held in reset.
  assign cpu_stall = reset_n & stall_raw;
  assign cpu_rdata = (reset_n && (state_q == IDLE) && cpu_rd && hit)
                     ? data_q[WIDX_BITS'({addr_idx, addr_off})] : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      wr_done_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wr_done_q <= wr_done_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wr_done_d   = wr_done_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    stall_raw   = 1'b0;
    fill_we     = 1'b0;
    fill_commit = 1'b0;
    fill_inval  = 1'b0;
    store_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          // A store that already completed in memory lets the pipeline advance once.
          if (wr_done_q) begin
            wr_done_d = 1'b0;
          end else begin
            stall_raw   = 1'b1;
            state_d     = WR_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {cpu_addr[31:2], 2'b00};
            mem_wdata_d = cpu_wdata;
          end
        end else if (cpu_rd && !hit) begin
          stall_raw  = 1'b1;
          state_d    = RD_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {cpu_addr[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
        end
      end
      RD_REQ: begin
        stall_raw = 1'b1;
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          beat_d     = '0;
          fill_inval = 1'b1;
          state_d    = RD_BEAT;
        end
      end
      RD_BEAT: begin
        stall_raw = 1'b1;
        if (mem_valid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + OFFSET_BITS'(1);
          if (beat_q == OFFSET_BITS'(LINE_WORDS - 1)) begin
            fill_commit = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WR_REQ: begin
        stall_raw = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          wr_done_d = 1'b1;
          store_we  = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is invalidated when its refill is accepted and only revalidated on the last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (fill_inval) begin
      valid_q[addr_idx] <= 1'b0;
    end else if (fill_commit) begin
      valid_q[addr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[WIDX_BITS'({addr_idx, beat_q})] <= mem_rdata;
    end
    if (store_we) begin
      data_q[WIDX_BITS'({addr_idx, addr_off})] <= cpu_wdata;
    end
    if (fill_commit) begin
      tag_q[addr_idx] <= addr_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: refills, hits, write-through stores,
// aliasing and reset during a burst, against a small backing-memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_over [logic [31:0]];

  dcache_ctrl #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues a load and plays memory; returns early if reset is pulsed at beat reset_beat.
  task automatic do_read(input string tag, input logic [31:0] addr, input bit exp_miss,
                         input int accept, input int reset_beat);
    int n, reqs, beat;
    bit accepted, saw_req;
    logic [31:0] req_addr, line;
    logic req_we;
    line = {addr[31:4], 4'h0};
    n = 0; reqs = 0; beat = 0; accepted = 0; saw_req = 0;
    req_addr = 32'h0; req_we = 1'b0;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = addr;
    #1;
    while (cpu_stall && n < 40) begin
      n++;
      if (accepted && beat < 4) begin
        if (beat == reset_beat) begin
          reset_n = 1'b0;
          #1;
          chk({tag, "_rst_req"}, 32'(mem_req), 32'h0);
          chk({tag, "_rst_stall"}, 32'(cpu_stall), 32'h0);
          @(negedge clk);
          cpu_rd = 1'b0;
          reset_n = 1'b1;
          return;
        end
        mem_valid = 1'b1;
        mem_rdata = mem_word(line + 32'(4 * beat));
        beat++;
      end
      if (mem_req) begin
        if (!saw_req) begin
          req_addr = mem_addr;
          req_we   = mem_we;
        end
        saw_req = 1'b1;
        reqs++;
        if (reqs == accept) begin
          mem_ready = 1'b1;
          accepted  = 1'b1;
        end
      end
      @(negedge clk);
      mem_ready = 1'b0; mem_valid = 1'b0;
      #1;
    end
    chk({tag, "_timeout"}, 32'(n < 40), 32'h1);
    chk({tag, "_stall_cycles"}, 32'(n), exp_miss ? 32'(accept + 5) : 32'h0);
    chk({tag, "_saw_req"}, 32'(saw_req), 32'(exp_miss));
    if (exp_miss) begin
      chk({tag, "_req_addr"}, req_addr, line);
      chk({tag, "_req_we"}, 32'(req_we), 32'h0);
    end
    chk({tag, "_rdata"}, cpu_rdata, mem_word({addr[31:2], 2'b00}));
  endtask

  // Issues a store and plays memory; stall must drop the cycle after acceptance.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int accept);
    int n, reqs, writes;
    logic [31:0] req_addr, req_wdata;
    logic req_we;
    n = 0; reqs = 0; writes = 0;
    req_addr = 32'h0; req_wdata = 32'h0; req_we = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = addr; cpu_wdata = data;
    #1;
    while (cpu_stall && n < 40) begin
      n++;
      if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          req_addr = mem_addr; req_wdata = mem_wdata; req_we = mem_we;
        end
        if (reqs == accept) begin
          mem_ready = 1'b1;
          if (mem_we) writes++;
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
    end
    chk({tag, "_timeout"}, 32'(n < 40), 32'h1);
    chk({tag, "_stall_cycles"}, 32'(n), 32'(accept + 1));
    chk({tag, "_writes"}, 32'(writes), 32'h1);
    chk({tag, "_req_addr"}, req_addr, {addr[31:2], 2'b00});
    chk({tag, "_req_wdata"}, req_wdata, data);
    chk({tag, "_req_we"}, 32'(req_we), 32'h1);
    mem_over[{addr[31:2], 2'b00}] = data;
    @(negedge clk);
    cpu_wr = 1'b0;
    #1;
    chk({tag, "_idle_after"}, 32'({cpu_stall, mem_req}), 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_no_activity", 32'({cpu_stall, mem_req}), 32'h0);

    do_read("t1_cold", 32'h0000_0100, 1'b1, 2, -1);
    do_read("t2_hit", 32'h0000_0104, 1'b0, 2, -1);

    do_write("t3_store", 32'h0000_0108, 32'hDEAD_BEEF, 3);
    do_read("t3_reread", 32'h0000_0108, 1'b0, 2, -1);

    do_write("t4_store_miss", 32'h0000_2000, 32'h1234_5678, 1);
    do_read("t4_read_miss", 32'h0000_2000, 1'b1, 1, -1);

    do_read("t5_hit_a", 32'h0000_0100, 1'b0, 2, -1);
    do_read("t5_alias_b", 32'h0000_0500, 1'b1, 3, -1);
    do_read("t5_a_again", 32'h0000_0100, 1'b1, 1, -1);
    do_read("t5_store_kept", 32'h0000_0108, 1'b0, 1, -1);

    do_read("t6_abort", 32'h0000_0300, 1'b1, 2, 2);
    do_read("t6_reread", 32'h0000_0300, 1'b1, 2, -1);
    do_read("t6_hit_after", 32'h0000_030C, 1'b0, 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
